// File: rtl/stream_fork_dynamic_reg_if.sv
// Handshake bundle for stream_fork_dynamic_reg: input beat + selection mask on one
// side, N_OUP replayed output streams on the other. Signal names follow the block's port list.
interface stream_fork_dynamic_reg_if #(
  parameter int unsigned N_OUP      = 2,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic [N_OUP-1:0]      sel_i;
  logic                  sel_valid_i;
  logic                  sel_ready_o;
  logic [N_OUP-1:0]      valid_o;
  logic [N_OUP-1:0]      ready_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic [N_OUP-1:0]      pending_o;
  logic                  idle_o;

  modport slave (
    input  valid_i, data_i, sel_i, sel_valid_i, ready_i,
    output ready_o, sel_ready_o, valid_o, data_o, pending_o, idle_o
  );

  modport master (
    output valid_i, data_i, sel_i, sel_valid_i, ready_i,
    input  ready_o, sel_ready_o, valid_o, data_o, pending_o, idle_o
  );
endinterface

// File: rtl/stream_fork_dynamic_reg.sv
// Registered dynamic stream fork: holds one beat with its selection mask and replays it
// to every selected output, each output handshaking exactly once.
module stream_fork_dynamic_reg #(
  parameter int unsigned N_OUP        = 2,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter bit          BACK_TO_BACK = 1'b1
) (
  input logic                      clk_i,
  input logic                      rst_i,
  stream_fork_dynamic_reg_if.slave bus
);

  if (N_OUP < 1) begin : g_bad_n_oup
    $fatal(1, "stream_fork_dynamic_reg: N_OUP must be >= 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $fatal(1, "stream_fork_dynamic_reg: DATA_WIDTH must be >= 1");
  end

  logic                  full_q, full_d;
  logic [N_OUP-1:0]      pend_q, pend_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic             last_now;
  logic             space;
  logic             ready;
  logic             accept;
  logic [N_OUP-1:0] hs;

  always_comb begin
    last_now = full_q && ((pend_q & ~bus.ready_i) == '0);
    // With BACK_TO_BACK=0 space depends only on full_q, keeping ready_i off the ready path.
    space    = !full_q || (BACK_TO_BACK && last_now);
    ready    = bus.sel_valid_i && space && !rst_i;
    accept   = bus.valid_i && bus.sel_valid_i && ready;
    hs       = {N_OUP{full_q}} & pend_q & bus.ready_i;

    full_d = full_q;
    pend_d = pend_q & ~hs;
    data_d = data_q;

    if (accept) begin
      if (bus.sel_i != '0) begin
        data_d = bus.data_i;
        pend_d = bus.sel_i;
        full_d = 1'b1;
      end else begin
        // An empty mask drops the beat; accept implies the register is empty or draining.
        full_d = 1'b0;
        pend_d = '0;
      end
    end else if (last_now) begin
      full_d = 1'b0;
      pend_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      pend_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

  assign bus.ready_o     = ready;
  assign bus.sel_ready_o = ready;
  assign bus.valid_o     = {N_OUP{full_q && !rst_i}} & pend_q;
  assign bus.data_o      = data_q;
  assign bus.pending_o   = pend_q & {N_OUP{full_q}};
  assign bus.idle_o      = !full_q;

endmodule

// File: tb/tb_stream_fork_dynamic_reg.sv
// Directed bench for stream_fork_dynamic_reg: a back-to-back instance checked against a
// beat scoreboard, plus a registered-ready (BACK_TO_BACK=0) instance.
module tb_stream_fork_dynamic_reg;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [N-1:0]  pend;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_fork_dynamic_reg_if #(.N_OUP(N), .DATA_WIDTH(DW)) a_if ();
  stream_fork_dynamic_reg_if #(.N_OUP(N), .DATA_WIDTH(DW)) b_if ();

  stream_fork_dynamic_reg #(.N_OUP(N), .DATA_WIDTH(DW), .BACK_TO_BACK(1'b1)) dut_a (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (a_if.slave)
  );

  stream_fork_dynamic_reg #(.N_OUP(N), .DATA_WIDTH(DW), .BACK_TO_BACK(1'b0)) dut_b (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (b_if.slave)
  );

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle on dut_a: drive, check outputs against the scoreboard, then advance.
  task automatic step(input logic v, input logic sv, input logic [N-1:0] sel,
                      input logic [DW-1:0] d, input logic [N-1:0] rdy,
                      input logic exp_rdy, input string tag);
    logic [N-1:0] hs;
    logic [N-1:0] exp_valid;
    ent_t         e;
    a_if.valid_i     = v;
    a_if.sel_valid_i = sv;
    a_if.sel_i       = sel;
    a_if.data_i      = d;
    a_if.ready_i     = rdy;
    #1;
    exp_valid = (sb.size() != 0) ? sb[0].pend : '0;
    chk({tag, " ready_o"}, a_if.ready_o, exp_rdy);
    chk({tag, " sel_ready_o"}, a_if.sel_ready_o, exp_rdy);
    chk({tag, " valid_o"}, a_if.valid_o, exp_valid);
    chk({tag, " pending_o"}, a_if.pending_o, exp_valid);
    chk({tag, " idle_o"}, a_if.idle_o, sb.size() == 0);
    hs = a_if.valid_o & rdy;
    if (hs != '0) begin
      if (sb.size() == 0) begin
        chk({tag, " unexpected handshake"}, hs, '0);
      end else begin
        chk({tag, " data_o"}, a_if.data_o, sb[0].data);
        e      = sb[0];
        e.pend = e.pend & ~hs;
        if (e.pend == '0) void'(sb.pop_front());
        else sb[0] = e;
      end
    end
    if (v && sv && exp_rdy && sel != '0) sb.push_back('{data: d, pend: sel});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst              = 1'b1;
    a_if.valid_i     = 1'b1;
    a_if.sel_valid_i = 1'b1;
    a_if.sel_i       = 4'b1111;
    a_if.data_i      = '0;
    a_if.ready_i     = '1;
    b_if.valid_i     = 1'b1;
    b_if.sel_valid_i = 1'b1;
    b_if.sel_i       = 4'b1111;
    b_if.data_i      = '0;
    b_if.ready_i     = '1;
    #1;
    chk("rst ready_o a", a_if.ready_o, 1'b0);
    chk("rst ready_o b", b_if.ready_o, 1'b0);
    chk("rst valid_o a", a_if.valid_o, '0);
    repeat (2) @(posedge clk);
    #1;
    a_if.valid_i     = 1'b0;
    a_if.sel_valid_i = 1'b0;
    b_if.valid_i     = 1'b0;
    b_if.sel_valid_i = 1'b0;
    rst              = 1'b0;
    #1;
    chk("post-rst valid_o", a_if.valid_o, '0);
    chk("post-rst pending_o", a_if.pending_o, '0);
    chk("post-rst idle_o", a_if.idle_o, 1'b1);
    chk("post-rst data_o", a_if.data_o, '0);

    // Back-to-back stream, all outputs ready.
    for (int unsigned i = 0; i < 4; i++)
      step(1'b1, 1'b1, 4'b0101, 32'hA0 + i, 4'b1111, 1'b1, "b2b");
    step(1'b0, 1'b0, '0, '0, 4'b1111, 1'b0, "b2b drain");
    step(1'b0, 1'b0, '0, '0, 4'b1111, 1'b0, "b2b idle");

    // Broadcast drained lane by lane; ready_o rises only with the last lane.
    step(1'b1, 1'b1, 4'b1111, 32'h55, 4'b0000, 1'b1, "lane acc");
    step(1'b0, 1'b1, '0, '0, 4'b0001, 1'b0, "lane0");
    step(1'b0, 1'b1, '0, '0, 4'b0010, 1'b0, "lane1");
    step(1'b0, 1'b1, '0, '0, 4'b0100, 1'b0, "lane2");
    step(1'b0, 1'b1, '0, '0, 4'b1000, 1'b1, "lane3");
    step(1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, "lane idle");

    // Empty mask: consumed and dropped.
    step(1'b1, 1'b1, 4'b0000, 32'h77, 4'b1111, 1'b1, "sel0 acc");
    step(1'b0, 1'b0, '0, '0, 4'b1111, 1'b0, "sel0 after");

    // Reset while a beat is held.
    step(1'b1, 1'b1, 4'b0110, 32'h99, 4'b0000, 1'b1, "mid acc");
    step(1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, "mid hold");
    rst              = 1'b1;
    a_if.sel_valid_i = 1'b1;
    #1;
    chk("mid rst ready_o", a_if.ready_o, 1'b0);
    chk("mid rst valid_o", a_if.valid_o, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_if.sel_valid_i = 1'b0;
    sb.delete();
    #1;
    chk("mid post valid_o", a_if.valid_o, '0);
    chk("mid post pending_o", a_if.pending_o, '0);
    chk("mid post idle_o", a_if.idle_o, 1'b1);
    chk("mid post data_o", a_if.data_o, '0);
    step(1'b1, 1'b1, 4'b0011, 32'h1234, 4'b0000, 1'b1, "re acc");
    step(1'b0, 1'b0, '0, '0, 4'b0011, 1'b0, "re hs");

    // Beat without mask waits; mask arrival accepts in the same cycle.
    for (int unsigned i = 0; i < 3; i++)
      step(1'b1, 1'b0, 4'b0001, 32'hBEEF, 4'b1111, 1'b0, "nosel");
    step(1'b1, 1'b1, 4'b0001, 32'hBEEF, 4'b1111, 1'b1, "sel arrive");
    step(1'b0, 1'b0, '0, '0, 4'b1111, 1'b0, "sel hs");
    chk("scoreboard empty", sb.size(), 0);

    // Registered-ready instance: one beat every other cycle.
    b_if.valid_i     = 1'b1;
    b_if.sel_valid_i = 1'b1;
    b_if.sel_i       = 4'b1111;
    b_if.ready_i     = 4'b1111;
    for (int unsigned k = 0; k < 8; k++) begin
      b_if.data_i = 32'hB0 + k;
      #1;
      chk("nb2b ready_o", b_if.ready_o, (k % 2) == 0);
      chk("nb2b valid_o", b_if.valid_o, ((k % 2) == 1) ? 4'b1111 : 4'b0000);
      if ((k % 2) == 1) chk("nb2b data_o", b_if.data_o, 32'hB0 + k - 1);
      @(posedge clk);
      #1;
    end
    b_if.data_i  = 32'hC0;
    b_if.ready_i = 4'b0000;
    #1;
    chk("nb2b empty ready_o", b_if.ready_o, 1'b1);
    @(posedge clk);
    #1;
    chk("nb2b held valid_o", b_if.valid_o, 4'b1111);
    chk("nb2b held data_o", b_if.data_o, 32'hC0);
    chk("nb2b rdy0 ready_o", b_if.ready_o, 1'b0);
    b_if.ready_i = 4'b1111;
    #1;
    chk("nb2b rdyF ready_o", b_if.ready_o, 1'b0);
    b_if.ready_i = 4'b0000;
    #1;
    chk("nb2b rdy0b ready_o", b_if.ready_o, 1'b0);
    b_if.valid_i     = 1'b0;
    b_if.sel_valid_i = 1'b0;
    b_if.ready_i     = 4'b1111;
    @(posedge clk);
    #1;
    chk("nb2b final idle_o", b_if.idle_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
